// File: rtl/pipe_stall_ctrl_pkg.sv
// rtl/pipe_stall_ctrl_pkg.sv - shared state encoding and defaults for the pipeline stall controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  localparam int TIMEOUT_DEFAULT = 255;

  // Bits needed to hold 0..limit inclusive, never less than one.
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - hazard inputs and pipeline-register control outputs of the stall controller
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             loaduse_i;
  logic             branch_taken_i;
  logic             dmem_req_i;
  logic             dmem_ack_i;
  logic             pc_hold_o;
  logic             ifid_hold_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             exmem_hold_o;
  logic             memwb_bubble_o;
  logic             err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output loaduse_i, branch_taken_i, dmem_req_i, dmem_ack_i,
    input  pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o,
    input  exmem_hold_o, memwb_bubble_o, err_o, stall_cnt_o
  );

  modport slave (
    input  loaduse_i, branch_taken_i, dmem_req_i, dmem_ack_i,
    output pc_hold_o, ifid_hold_o, ifid_flush_o, idex_bubble_o,
    output exmem_hold_o, memwb_bubble_o, err_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// rtl/pipe_stall_ctrl_sat_counter.sv - up counter with synchronous clear that stops at LIMIT
module sat_counter #(
  parameter int           W     = 8,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - stall/flush control for a 5-stage pipeline; STALL_PERF_EN enables the stall counter
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_stall_ctrl_if.slave   bus
);

  localparam int WAIT_W = cnt_width(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  state_e            state_q;
  logic              flush_pend_q, flush_pend_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              err_state, wait_start, mem_stall, lu_stall, br_flush, hold;

  assign err_state  = (state_q == ERR);
  assign wait_start = (state_q == RUN) && bus.dmem_req_i && !bus.dmem_ack_i;
  assign mem_stall  = wait_start || ((state_q == MEM_WAIT) && !bus.dmem_ack_i);
  assign lu_stall   = !err_state && !mem_stall && bus.loaduse_i;
  assign br_flush   = !err_state && !mem_stall && !lu_stall &&
                      (bus.branch_taken_i || flush_pend_q);

  // Every control output is forced low while reset is held, independent of the clock.
  assign hold               = !rst_i && (err_state || mem_stall || lu_stall);
  assign bus.pc_hold_o      = hold;
  assign bus.ifid_hold_o    = hold;
  assign bus.ifid_flush_o   = !rst_i && br_flush && !hold;
  assign bus.idex_bubble_o  = !rst_i && lu_stall;
  assign bus.exmem_hold_o   = !rst_i && (err_state || mem_stall);
  assign bus.memwb_bubble_o = !rst_i && (err_state || mem_stall);
  assign bus.err_o          = err_state;

  // A branch resolved under any stall is remembered until the first free cycle.
  always_comb begin
    flush_pend_d = flush_pend_q;
    if (!err_state) begin
      if (mem_stall || lu_stall) begin
        flush_pend_d = flush_pend_q || bus.branch_taken_i;
      end else begin
        flush_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
    end else begin
      flush_pend_q <= flush_pend_d;
      case (state_q)
        RUN:      if (wait_start) state_q <= MEM_WAIT;
        MEM_WAIT: begin
          if (bus.dmem_ack_i) begin
            state_q <= RUN;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state_q <= ERR;
          end
        end
        ERR:      state_q <= ERR;
        default:  state_q <= RUN;
      endcase
    end
  end

  sat_counter #(
    .W     (WAIT_W),
    .LIMIT (WAIT_LIMIT)
  ) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (wait_start),
    .en_i  (state_q == MEM_WAIT),
    .cnt_o (wait_cnt)
  );

`ifdef STALL_PERF_EN
  sat_counter #(
    .W     (CNT_W),
    .LIMIT ({CNT_W{1'b1}})
  ) u_perf_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (1'b0),
    .en_i  (hold),
    .cnt_o (bus.stall_cnt_o)
  );
`else
  assign bus.stall_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - randomized and directed checks of pipe_stall_ctrl against a cycle-level model
module tb_pipe_stall_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_stall_ctrl #(
    .TIMEOUT (TMO),
    .CNT_W   (CW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Model: waited < 0 means no access outstanding, else count of wait cycles already spent.
  int     waited = -1;
  bit     dead   = 1'b0;
  bit     pend   = 1'b0;
  longint perf   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt();
`ifdef STALL_PERF_EN
    return (perf > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : 64'(perf);
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [6:0] outs();
    return {bus.pc_hold_o, bus.ifid_hold_o, bus.ifid_flush_o, bus.idex_bubble_o,
            bus.exmem_hold_o, bus.memwb_bubble_o, bus.err_o};
  endfunction

  task automatic step(input bit lu, input bit br, input bit req, input bit ack);
    bit mem = 1'b0;
    bit lus = 1'b0;
    bit fl  = 1'b0;
    logic [6:0] e;
    @(negedge clk);
    bus.loaduse_i      = lu;
    bus.branch_taken_i = br;
    bus.dmem_req_i     = req;
    bus.dmem_ack_i     = ack;
    #1;
    if (dead) begin
      e = 7'b1100111;
    end else begin
      mem = (waited < 0) ? (req && !ack) : !ack;
      lus = !mem && lu;
      fl  = !mem && !lus && (br || pend);
      e   = {mem | lus, mem | lus, fl, lus, mem, mem, 1'b0};
    end
    check("ctl", 64'(outs()), 64'(e));
    check("cnt", 64'(bus.stall_cnt_o), exp_cnt());
    if (!dead) begin
      pend = (mem || lus) ? (pend || br) : 1'b0;
      if (waited < 0) begin
        if (req && !ack) waited = 0;
      end else if (ack) begin
        waited = -1;
      end else if (waited == TMO) begin
        dead = 1'b1;
      end else begin
        waited++;
      end
    end
    if (e[6]) perf++;
  endtask

  // Reset lands between clock edges with the previous inputs still applied.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_ctl", 64'(outs()), 64'd0);
    check("rst_cnt", 64'(bus.stall_cnt_o), 64'd0);
    waited = -1;
    dead   = 1'b0;
    pend   = 1'b0;
    perf   = 0;
    @(negedge clk);
    rst = 1'b0;
    bus.loaduse_i      = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.dmem_req_i     = 1'b0;
    bus.dmem_ack_i     = 1'b0;
  endtask

  initial begin
    bus.loaduse_i      = 1'b1;
    bus.branch_taken_i = 1'b1;
    bus.dmem_req_i     = 1'b1;
    bus.dmem_ack_i     = 1'b0;
    #3;
    check("init_ctl", 64'(outs()), 64'd0);
    check("init_cnt", 64'(bus.stall_cnt_o), 64'd0);
    do_reset();

    // single load-use cycle
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    // memory access acknowledged on the fourth cycle
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    // branch while waiting on memory, flush released once the access completes
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // load-use and branch together
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // timeout into the error state, inputs ignored there
    step(0, 0, 1, 0);
    for (int i = 0; i < TMO + 4; i++) step(1'(i), 1'(i >> 1), 1, 0);
    step(0, 1, 1, 1);
    do_reset();
    step(0, 0, 0, 0);
    // reset in the middle of a wait with a pending flush
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      step($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
